// File: rtl/updown_game_ctrl.sv
// -----------------------------------------------------------------------------
// updown_game_ctrl
//   Sequencer for the up/down number-guessing game. Draws a target from the
//   free-running LFSR value by rejection sampling into [MIN_VAL, MAX_VAL],
//   accepts player guesses on a valid strobe, issues up/down/correct hints,
//   counts attempts and declares win or loss against MAX_TRIES.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle request to begin (or restart) a round
//   rnd_in[6:0]  random value, sampled while drawing
//   guess_valid  one-cycle strobe qualifying guess
//   guess[6:0]   player guess
//   drawing      waiting for an in-range random value
//   playing      guesses are accepted
//   hint_up      last in-range guess was below the target
//   hint_down    last in-range guess was above the target
//   correct      last in-range guess equalled the target
//   bad_guess    one-cycle pulse for a guess outside [MIN_VAL, MAX_VAL]
//   attempts     in-range guesses counted this round
//   game_over    round ended (win or lose)
//   win          round ended on a correct guess
//   target       drawn target, visible only while game_over is high
// -----------------------------------------------------------------------------
module updown_game_ctrl #(
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 100,
    parameter int MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] rnd_in,
    input  logic       guess_valid,
    input  logic [6:0] guess,
    output logic       drawing,
    output logic       playing,
    output logic       hint_up,
    output logic       hint_down,
    output logic       correct,
    output logic       bad_guess,
    output logic [3:0] attempts,
    output logic       game_over,
    output logic       win,
    output logic [6:0] target
);

    localparam logic [6:0] LO    = 7'(MIN_VAL);
    localparam logic [6:0] HI    = 7'(MAX_VAL);
    localparam logic [3:0] TRIES = 4'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, DRAW, PLAY, DONE} state_t;

    state_t     state;
    logic [6:0] target_q;   // retained across rounds; only exported in DONE

    logic       rnd_ok;
    logic       guess_ok;
    logic       guess_hit;
    logic [3:0] attempts_next;

    assign rnd_ok        = (rnd_in >= LO) && (rnd_in <= HI);
    assign guess_ok      = (guess >= LO) && (guess <= HI);
    assign guess_hit     = (guess == target_q);
    assign attempts_next = attempts + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            target_q  <= '0;
            drawing   <= 1'b0;
            playing   <= 1'b0;
            hint_up   <= 1'b0;
            hint_down <= 1'b0;
            correct   <= 1'b0;
            bad_guess <= 1'b0;
            attempts  <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
            target    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // sees the register values from before this edge; the default
            // below is overridden later in the block to make a 1-cycle pulse.
            bad_guess <= 1'b0;

            // start has priority in every state: it aborts any round in
            // progress and any guess strobed in the same cycle is dropped.
            if (start) begin
                state     <= DRAW;
                drawing   <= 1'b1;
                playing   <= 1'b0;
                hint_up   <= 1'b0;
                hint_down <= 1'b0;
                correct   <= 1'b0;
                attempts  <= '0;
                game_over <= 1'b0;
                win       <= 1'b0;
                target    <= '0;
            end else begin
                case (state)
                    DRAW: begin
                        // Rejection sampling keeps the draw uniform over the
                        // range; an out-of-range value just costs a cycle.
                        if (rnd_ok) begin
                            target_q <= rnd_in;
                            state    <= PLAY;
                            drawing  <= 1'b0;
                            playing  <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (guess_valid) begin
                            if (!guess_ok) begin
                                bad_guess <= 1'b1;
                            end else begin
                                attempts  <= attempts_next;
                                hint_up   <= (guess < target_q);
                                hint_down <= (guess > target_q);
                                correct   <= guess_hit;
                                // Reaching the limit on a miss ends the round;
                                // attempts therefore never exceeds MAX_TRIES.
                                if (guess_hit || (attempts_next >= TRIES)) begin
                                    state     <= DONE;
                                    playing   <= 1'b0;
                                    game_over <= 1'b1;
                                    win       <= guess_hit;
                                    target    <= target_q;
                                end
                            end
                        end
                    end
                    IDLE, DONE: begin
                        // Only start leaves these states; guesses are ignored.
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
